pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the stall performance counter.
REQ-002 SHALL have parameter DWAIT_LIMIT, default 255: maximum DWAIT cycles before a timeout is flagged.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port fw_halt, input, 1: load-use halt request from forwarding logic.
REQ-006 SHALL have port br_redirect_ex, input, 1: taken branch or jump resolved in EX.
REQ-007 SHALL have port icache_miss, input, 1: fetch data not valid this cycle.
REQ-008 SHALL have port dcache_miss, input, 1: MEM-stage data access not complete.
REQ-009 SHALL have port cnt_clr, input, 1: synchronous clear of stall_cnt.
REQ-010 SHALL have ports pc_en, if_id_en, id_ex_en, ex_mem_en and mem_wb_en, output, 1 each: stage register load enables.
REQ-011 SHALL have ports if_id_flush, id_ex_flush and ex_mem_flush, output, 1 each: load a bubble (NOP, reg_wen=0) into that register.
REQ-012 SHALL have port state_o, output, 2: current FSM state encoding.
REQ-013 SHALL have port stall_cnt, output, CNT_W: cycles in which any enable was 0.
REQ-014 SHALL have port timeout_err, output, 1: sticky DWAIT timeout flag.

Function
REQ-015 SHALL implement FSM states RUN=2'd0, DWAIT=2'd1, HALT=2'd2, IWAIT=2'd3.
REQ-016 SHALL compute enables and flushes combinationally from state and inputs, with fixed priority dcache_miss > fw_halt > br_redirect_ex > icache_miss.
REQ-017 SHALL, when dcache_miss=1 in any state, drive all five enables 0 and all flushes 0, with next state DWAIT.
REQ-018 SHALL, in DWAIT, return to RUN on the first cycle dcache_miss=0; that cycle SHALL be evaluated with RUN rules.
REQ-019 SHALL, in RUN when fw_halt=1 and dcache_miss=0, drive pc_en, if_id_en and id_ex_en to 0, ex_mem_en and mem_wb_en to 1, and ex_mem_flush to 1, with next state HALT.
REQ-020 SHALL, in HALT, ignore fw_halt, enable all stages, and go to RUN after exactly 1 cycle; this bounds load-use to 1 bubble.
REQ-021 SHALL, when br_redirect_ex=1 (no higher priority input active), enable all stages and drive if_id_flush=1 and id_ex_flush=1; icache_miss SHALL be ignored that cycle.
REQ-022 SHALL, when icache_miss=1 (no higher priority input active), drive pc_en=0, if_id_en=1, if_id_flush=1 and downstream enables 1, with next state IWAIT; IWAIT SHALL exit to RUN when icache_miss=0.
REQ-023 SHALL, with no request active, drive all enables 1 and all flushes 0.
REQ-024 SHALL never assert a flush on a register whose enable is 0.
REQ-025 SHALL increment stall_cnt by 1 in every cycle where any enable is 0, saturating at all-ones.
REQ-026 SHALL give cnt_clr priority over increment: next value 0.
REQ-027 SHALL count consecutive DWAIT cycles in an internal counter that clears on leaving DWAIT.
REQ-028 SHALL set timeout_err when that counter reaches DWAIT_LIMIT; timeout_err SHALL be cleared only by reset.
REQ-029 SHALL drive state_o directly from the state register.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, load state RUN, stall_cnt 0, DWAIT counter 0 and timeout_err 0.
REQ-031 SHALL, while rst_n=0, drive all enables 1 and all flushes 1 so every stage register loads a bubble.
REQ-032 SHALL let reset override any state, including mid-DWAIT and mid-HALT, with normal operation from the first cycle after rst_n=1.

Verification
REQ-033 SHALL cover: fw_halt 1 for 2 cycles from RUN -> cycle 0: pc/if_id/id_ex en=0, ex_mem_flush=1; cycle 1: HALT, all en=1; stall_cnt=1.
REQ-034 SHALL cover: dcache_miss for 5 cycles with fw_halt and br_redirect_ex also 1 -> all en=0, no flush, for 5 cycles; stall_cnt=5; RUN after.
REQ-035 SHALL cover: br_redirect_ex and icache_miss together -> pc_en=1, if_id_flush=id_ex_flush=1, state stays RUN.
REQ-036 SHALL cover: dcache_miss held 300 cycles with DWAIT_LIMIT=255 -> timeout_err rises after 255 DWAIT cycles and remains 1 after the miss clears.
REQ-037 SHALL cover: CNT_W=4 with 20 stall cycles -> stall_cnt=15; then cnt_clr with a simultaneous stall -> 0.
REQ-038 SHALL cover: rst_n=0 asserted mid-DWAIT -> next edge state_o=0, counters 0, all flushes 1 during reset.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush controller for a classic five-stage in-order pipeline
// (IF, ID, EX, MEM, WB). It arbitrates between four hazard sources and drives
// the load enables and bubble-insert (flush) controls of the pipeline
// registers. It also keeps a saturating stall-cycle performance counter and a
// sticky watchdog flag for data-cache waits that never complete.
//
// Hazard priority, highest first:
//   dcache_miss    -> freeze the whole pipeline
//   fw_halt        -> hold IF/ID/EX, inject one bubble into EX/MEM
//   br_redirect_ex -> squash the two younger instructions in IF/ID and ID/EX
//   icache_miss    -> hold the PC, feed a bubble into IF/ID
//
// Parameters
//   CNT_W        width of the stall performance counter
//   DWAIT_LIMIT  consecutive DWAIT cycles after which timeout_err is raised
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   fw_halt        load-use halt request from the forwarding unit
//   br_redirect_ex taken branch / jump resolved in EX
//   icache_miss    fetch data not valid this cycle
//   dcache_miss    MEM-stage data access not complete
//   cnt_clr        synchronous clear of stall_cnt
//   pc_en .. mem_wb_en              stage register load enables
//   if_id_flush .. ex_mem_flush     load a bubble into that register
//   state_o        current FSM state (RUN=0, DWAIT=1, HALT=2, IWAIT=3)
//   stall_cnt      cycles in which any enable was low (saturating)
//   timeout_err    sticky DWAIT timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int DWAIT_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fw_halt,
  input  logic             br_redirect_ex,
  input  logic             icache_miss,
  input  logic             dcache_miss,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2,
    IWAIT = 2'd3
  } state_t;

  // The winning hazard for this cycle; both next-state and output logic key
  // off this single decode so the priority order lives in exactly one place.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_DMISS,
    ACT_HALT,
    ACT_REDIR,
    ACT_IMISS
  } act_t;

  // Wide enough to hold DWAIT_LIMIT itself.
  localparam int DW_W = (DWAIT_LIMIT < 1) ? 1 : $clog2(DWAIT_LIMIT + 1);
  localparam logic [DW_W-1:0] DW_LIMIT = DW_W'(DWAIT_LIMIT);

  state_t            state_q;
  state_t            state_d;
  act_t              act;
  logic              any_stall;
  logic [DW_W-1:0]   dwait_cnt_q;
  logic [DW_W-1:0]   dwait_cnt_d;

  // ---------------------------------------------------------------------------
  // Hazard arbitration.
  // DWAIT and IWAIT need no state-specific rules: a DWAIT cycle with
  // dcache_miss low and an IWAIT cycle with icache_miss low both fall through
  // to the ordinary RUN evaluation. HALT differs only in that fw_halt is
  // masked, which bounds a load-use stall to a single bubble even if the
  // forwarding unit keeps asserting it.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the block leaves it unassigned (which would infer a latch).
    act = ACT_NONE;
    if (dcache_miss) begin
      act = ACT_DMISS;
    end else if (fw_halt && (state_q != HALT)) begin
      act = ACT_HALT;
    end else if (br_redirect_ex) begin
      act = ACT_REDIR;
    end else if (icache_miss) begin
      act = ACT_IMISS;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. HALT always leaves after one cycle; a redirect keeps the
  // controller in RUN because the fetch it would have waited on is discarded.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = RUN;
    unique case (act)
      ACT_DMISS: state_d = DWAIT;
      ACT_HALT:  state_d = HALT;
      ACT_IMISS: state_d = IWAIT;
      default:   state_d = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. A flush is only ever raised alongside an enable of 1, so a
  // bubble is never requested into a register that is holding its contents.
  // While reset is held every register is enabled and flushed, so the whole
  // pipeline fills with bubbles during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;

    if (!rst_n) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      unique case (act)
        ACT_DMISS: begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end
        ACT_HALT: begin
          // The load proceeds into MEM; EX/MEM receives a bubble in place of
          // the dependent instruction, which is held in ID/EX.
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
        end
        ACT_REDIR: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        ACT_IMISS: begin
          // Hold the PC so the fetch is retried; the instruction already in
          // IF/ID moves on and a bubble takes its place.
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign any_stall = ~(pc_en & if_id_en & id_ex_en & ex_mem_en & mem_wb_en);

  // Consecutive cycles spent waiting in DWAIT. A DWAIT cycle in which the miss
  // has resolved is the exit cycle and clears the count.
  always_comb begin
    dwait_cnt_d = '0;
    if ((state_q == DWAIT) && dcache_miss) begin
      dwait_cnt_d = (dwait_cnt_q == DW_LIMIT) ? dwait_cnt_q
                                              : dwait_cnt_q + DW_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State register, performance counter and watchdog.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q     <= RUN;
      stall_cnt   <= '0;
      dwait_cnt_q <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwait_cnt_q <= dwait_cnt_d;

      if (cnt_clr) begin
        stall_cnt <= '0;
      end else if (any_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end

      if (dwait_cnt_d == DW_LIMIT) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign state_o = state_q;

  // A flush into a frozen register would be silently lost.
  a_no_flush_when_held : assert property (@(posedge clk)
    !(if_id_flush && !if_id_en) && !(id_ex_flush && !id_ex_en) &&
    !(ex_mem_flush && !ex_mem_en));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pipeline_hazard_ctrl.
// u_dut uses the default parameters; u_dut4 narrows the stall counter to four
// bits to exercise saturation. Both see the same stimulus.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, fw_halt, br_redirect_ex, icache_miss, dcache_miss, cnt_clr;

  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt;
  logic        timeout_err;

  logic        pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4;
  logic        if_id_flush4, id_ex_flush4, ex_mem_flush4;
  logic [1:0]  state_o4;
  logic [3:0]  stall_cnt4;
  logic        timeout_err4;

  pipeline_hazard_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .fw_halt(fw_halt), .br_redirect_ex(br_redirect_ex),
    .icache_miss(icache_miss), .dcache_miss(dcache_miss), .cnt_clr(cnt_clr),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .state_o(state_o), .stall_cnt(stall_cnt),
    .timeout_err(timeout_err)
  );

  pipeline_hazard_ctrl #(.CNT_W(4), .DWAIT_LIMIT(255)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .fw_halt(fw_halt), .br_redirect_ex(br_redirect_ex),
    .icache_miss(icache_miss), .dcache_miss(dcache_miss), .cnt_clr(cnt_clr),
    .pc_en(pc_en4), .if_id_en(if_id_en4), .id_ex_en(id_ex_en4),
    .ex_mem_en(ex_mem_en4), .mem_wb_en(mem_wb_en4),
    .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
    .ex_mem_flush(ex_mem_flush4), .state_o(state_o4), .stall_cnt(stall_cnt4),
    .timeout_err(timeout_err4)
  );

  // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, ex_mem}
  typedef struct {
    logic        rst_n, dc, fw, br, ic, clr;
    logic [4:0]  en;
    logic [2:0]  fl;
    logic [1:0]  st;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic [4:0]  en;
    logic [2:0]  fl;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  function automatic vec_t mk(bit r, bit dc, bit fw, bit br, bit ic, bit clr,
                              logic [4:0] en, logic [2:0] fl,
                              logic [1:0] st, int cnt);
    vec_t v;
    v.rst_n = r; v.dc = dc; v.fw = fw; v.br = br; v.ic = ic; v.clr = clr;
    v.en = en; v.fl = fl; v.st = st; v.cnt = 16'(cnt);
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] en_vec();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  endfunction

  function automatic logic [2:0] fl_vec();
    return {if_id_flush, id_ex_flush, ex_mem_flush};
  endfunction

  // Drive one cycle's inputs at the falling edge, let outputs settle.
  task automatic cyc(bit r, bit dc, bit fw, bit br, bit ic, bit clr);
    @(negedge clk);
    rst_n = r; dcache_miss = dc; fw_halt = fw; br_redirect_ex = br;
    icache_miss = ic; cnt_clr = clr;
    #1;
  endtask

  vec_t tbl[25];

  initial begin
    rst_n = 1'b0; fw_halt = 1'b0; br_redirect_ex = 1'b0;
    icache_miss = 1'b0; dcache_miss = 1'b0; cnt_clr = 1'b0;

    //              r dc fw br ic clr  en        fl      st  cnt
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 5'b11111, 3'b111, 2'd0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd0, 0);
    tbl[2]  = mk(1, 0, 1, 0, 0, 0, 5'b00011, 3'b001, 2'd0, 0); // load-use
    tbl[3]  = mk(1, 0, 1, 0, 0, 0, 5'b11111, 3'b000, 2'd2, 1); // HALT ignores fw
    tbl[4]  = mk(1, 0, 0, 0, 0, 1, 5'b11111, 3'b000, 2'd0, 1);
    tbl[5]  = mk(1, 1, 1, 1, 0, 0, 5'b00000, 3'b000, 2'd0, 0); // dmiss wins
    tbl[6]  = mk(1, 1, 1, 1, 0, 0, 5'b00000, 3'b000, 2'd1, 1);
    tbl[7]  = mk(1, 1, 1, 1, 0, 0, 5'b00000, 3'b000, 2'd1, 2);
    tbl[8]  = mk(1, 1, 1, 1, 0, 0, 5'b00000, 3'b000, 2'd1, 3);
    tbl[9]  = mk(1, 1, 1, 1, 0, 0, 5'b00000, 3'b000, 2'd1, 4);
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd1, 5); // DWAIT exit
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd0, 5);
    tbl[12] = mk(1, 0, 0, 1, 1, 0, 5'b11111, 3'b110, 2'd0, 5); // redirect + imiss
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd0, 5);
    tbl[14] = mk(1, 0, 0, 0, 1, 0, 5'b01111, 3'b100, 2'd0, 5); // imiss
    tbl[15] = mk(1, 0, 0, 0, 1, 0, 5'b01111, 3'b100, 2'd3, 6);
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd3, 7); // IWAIT exit
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd0, 7);
    tbl[18] = mk(1, 1, 0, 0, 0, 0, 5'b00000, 3'b000, 2'd0, 7);
    tbl[19] = mk(1, 0, 1, 0, 0, 0, 5'b00011, 3'b001, 2'd1, 8); // DWAIT exit, RUN rules
    tbl[20] = mk(1, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd2, 9);
    tbl[21] = mk(1, 0, 1, 0, 1, 0, 5'b00011, 3'b001, 2'd0, 9); // fw beats imiss
    tbl[22] = mk(1, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd2, 10);
    tbl[23] = mk(1, 0, 1, 0, 0, 1, 5'b00011, 3'b001, 2'd0, 10); // clr beats inc
    tbl[24] = mk(1, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 2'd2, 0);

    repeat (2) @(posedge clk);

    // ---- table-driven vectors through the scoreboard ----
    for (int i = 0; i < 25; i++) begin
      exp_t e;
      @(negedge clk);
      rst_n = tbl[i].rst_n; dcache_miss = tbl[i].dc; fw_halt = tbl[i].fw;
      br_redirect_ex = tbl[i].br; icache_miss = tbl[i].ic; cnt_clr = tbl[i].clr;
      e.en = tbl[i].en; e.fl = tbl[i].fl; e.st = tbl[i].st; e.cnt = tbl[i].cnt;
      sb_q.push_back(e);
      #1;
      if (sb_q.size() == 0) begin
        check($sformatf("row%0d_sb_empty", i), 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("row%0d_en", i),    32'(en_vec()),  32'(e.en));
        check($sformatf("row%0d_flush", i), 32'(fl_vec()),  32'(e.fl));
        check($sformatf("row%0d_state", i), 32'(state_o),   32'(e.st));
        check($sformatf("row%0d_cnt", i),   32'(stall_cnt), 32'(e.cnt));
      end
    end

    // ---- DWAIT watchdog: miss held 300 cycles, limit 255 ----
    for (int i = 0; i < 300; i++) begin
      cyc(1, 1, 0, 0, 0, 0);
      if (i == 255) check("timeout_before_limit", 32'(timeout_err), 32'd0);
      if (i == 256) begin
        check("timeout_at_limit", 32'(timeout_err), 32'd1);
        check("dwait_en_frozen", 32'(en_vec()), 32'd0);
        check("dwait_state", 32'(state_o), 32'd1);
      end
    end
    cyc(1, 0, 0, 0, 0, 0);
    check("timeout_exit_cycle_en", 32'(en_vec()), 32'h1f);
    cyc(1, 0, 0, 0, 0, 0);
    check("timeout_sticky", 32'(timeout_err), 32'd1);
    check("timeout_back_to_run", 32'(state_o), 32'd0);

    // ---- reset mid-DWAIT ----
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    check("pre_reset_dwait", 32'(state_o), 32'd1);
    cyc(0, 1, 1, 0, 0, 0);
    check("reset_en_all_1", 32'(en_vec()), 32'h1f);
    check("reset_flush_all_1", 32'(fl_vec()), 32'h7);
    cyc(0, 1, 0, 0, 0, 0);
    check("reset_state_run", 32'(state_o), 32'd0);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_timeout_clr", 32'(timeout_err), 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    check("post_reset_flush", 32'(fl_vec()), 32'h0);
    check("post_reset_en", 32'(en_vec()), 32'h1f);

    // ---- reset mid-HALT ----
    cyc(1, 0, 1, 0, 0, 0);
    check("halt_entry_en", 32'(en_vec()), 32'h03);
    cyc(0, 0, 0, 0, 0, 0);
    check("reset_in_halt_state", 32'(state_o), 32'd2);
    check("reset_in_halt_flush", 32'(fl_vec()), 32'h7);
    cyc(1, 0, 0, 0, 0, 0);
    check("after_halt_reset_state", 32'(state_o), 32'd0);
    check("after_halt_reset_cnt", 32'(stall_cnt), 32'd0);

    // ---- 4-bit counter saturation and clear-vs-increment ----
    cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1);
    check("cnt4_saturated", 32'(stall_cnt4), 32'd15);
    check("cnt16_twenty", 32'(stall_cnt), 32'd20);
    cyc(1, 0, 0, 0, 0, 0);
    check("cnt4_cleared", 32'(stall_cnt4), 32'd0);
    check("cnt16_cleared", 32'(stall_cnt), 32'd0);
    check("sat_exit_state", 32'(state_o), 32'd1);
    cyc(1, 0, 0, 0, 0, 0);
    check("sat_run_state", 32'(state_o4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
